// File: rtl/param_memory.sv
// Simple dual-port synchronous memory with reset-driven init (entry i <= i),
// read-valid flag, selectable read-during-write policy and address-range flagging.
module param_memory #(
  parameter int DATA_W   = 15,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              wen,
  input  logic              ren,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic              r_q_valid;
  logic              r_busy;
  logic              r_addr_err;

  logic              w_wr_in;
  logic              w_rd_in;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_same;
  logic [DATA_W-1:0] w_init_data;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Init value is the counter modulo 2**DATA_W.
  if (DATA_W > ADDR_W) begin : g_init_ext
    assign w_init_data = DATA_W'(r_cnt);
  end else begin : g_init_trunc
    assign w_init_data = r_cnt[DATA_W-1:0];
  end

  assign w_wr_in = ({1'b0, w_addr} < DEPTH_C);
  assign w_rd_in = ({1'b0, r_addr} < DEPTH_C);
  assign w_wr_ok = (r_state == ST_READY) && wen && w_wr_in;
  assign w_rd_ok = (r_state == ST_READY) && ren && w_rd_in;
  assign w_same  = w_wr_ok && (w_addr == r_addr);

  // The array read sees the pre-edge contents, which gives old-data behaviour.
  assign w_rd_data = ((RDW_MODE != 0) && w_same) ? data : r_mem[r_addr[IDX_W-1:0]];

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if ((r_state == ST_INIT) && !reset) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt[IDX_W-1:0];
      w_mem_wdata = w_init_data;
    end else if (w_wr_ok) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = w_addr[IDX_W-1:0];
      w_mem_wdata = data;
    end
  end

  // Storage has no reset; the init sequencer rewrites every entry instead.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_busy     <= 1'b1;
      r_addr_err <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt      <= r_cnt + 1'b1;
      r_q_valid  <= 1'b0;
      r_addr_err <= 1'b0;
      if (r_cnt == LAST_C) begin
        r_state <= ST_READY;
        r_busy  <= 1'b0;
      end
    end else begin
      r_q_valid  <= w_rd_ok;
      r_addr_err <= (wen && !w_wr_in) || (ren && !w_rd_in);
      if (w_rd_ok) begin
        r_q <= w_rd_data;
      end
    end
  end

  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign busy     = r_busy;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench: three memory configurations share one stimulus stream and
// are checked against an array-based reference model of the memory behaviour.
module tb_param_memory;

  logic        clock;
  logic        reset;
  logic [14:0] data;
  logic [3:0]  w_addr;
  logic [3:0]  r_addr;
  logic        wen;
  logic        ren;
  logic [2:0]  data3;

  logic [14:0] q0, q1;
  logic [2:0]  q2;
  logic        v0, v1, v2;
  logic        b0, b1, b2;
  logic        e0, e1, e2;

  assign data3 = data[2:0];

  param_memory #(.DATA_W(15), .DEPTH(8), .ADDR_W(4), .RDW_MODE(0)) u_mem0 (
    .clock(clock), .reset(reset), .data(data), .w_addr(w_addr), .r_addr(r_addr),
    .wen(wen), .ren(ren), .q(q0), .q_valid(v0), .busy(b0), .addr_err(e0));

  param_memory #(.DATA_W(15), .DEPTH(8), .ADDR_W(4), .RDW_MODE(1)) u_mem1 (
    .clock(clock), .reset(reset), .data(data), .w_addr(w_addr), .r_addr(r_addr),
    .wen(wen), .ren(ren), .q(q1), .q_valid(v1), .busy(b1), .addr_err(e1));

  param_memory #(.DATA_W(3), .DEPTH(16), .ADDR_W(4), .RDW_MODE(0)) u_mem2 (
    .clock(clock), .reset(reset), .data(data3), .w_addr(w_addr), .r_addr(r_addr),
    .wen(wen), .ren(ren), .q(q2), .q_valid(v2), .busy(b2), .addr_err(e2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy;
    logic        v;
    logic        e;
    logic [14:0] q;
  } stat_t;

  stat_t       exp_st[$];
  logic [14:0] rd_q0[$];
  logic [14:0] rd_q1[$];
  logic [14:0] rd_q2[$];

  int checks = 0;
  int errors = 0;

  int m_mem[3][16];
  int m_left[3];
  int m_q[3];

  function automatic int dw(input int k);  return (k == 2) ? 3 : 15; endfunction
  function automatic int dep(input int k); return (k == 2) ? 16 : 8; endfunction
  function automatic int rdw(input int k); return (k == 1) ? 1 : 0; endfunction

  function automatic logic [14:0] out_q(input int k);
    case (k)
      0: return q0;
      1: return q1;
      default: return {12'd0, q2};
    endcase
  endfunction
  function automatic logic out_v(input int k); return (k == 0) ? v0 : (k == 1) ? v1 : v2; endfunction
  function automatic logic out_b(input int k); return (k == 0) ? b0 : (k == 1) ? b1 : b2; endfunction
  function automatic logic out_e(input int k); return (k == 0) ? e0 : (k == 1) ? e1 : e2; endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int k, input logic [14:0] val);
    case (k)
      0: rd_q0.push_back(val);
      1: rd_q1.push_back(val);
      default: rd_q2.push_back(val);
    endcase
  endtask

  // Reference: what each instance shows after the coming rising edge.
  task automatic model_edge(input int k, input bit rs, input bit we, input bit re,
                            input int wa, input int ra, input int d);
    int    mask;
    bit    v, e, wok, rok;
    stat_t s;
    mask = (1 << dw(k)) - 1;
    v = 0;
    e = 0;
    if (rs) begin
      m_left[k] = dep(k);
      m_q[k] = 0;
    end else if (m_left[k] > 0) begin
      m_mem[k][dep(k) - m_left[k]] = (dep(k) - m_left[k]) & mask;
      m_left[k]--;
    end else begin
      wok = we && (wa < dep(k));
      rok = re && (ra < dep(k));
      e = (we && !wok) || (re && !rok);
      if (rok) begin
        if (wok && (wa == ra) && (rdw(k) == 1)) m_q[k] = d & mask;
        else m_q[k] = m_mem[k][ra];
        v = 1;
        push_rd(k, 15'(m_q[k]));
      end
      if (wok) m_mem[k][wa] = d & mask;
    end
    s.busy = (m_left[k] > 0);
    s.v = v;
    s.e = e;
    s.q = 15'(m_q[k]);
    exp_st.push_back(s);
  endtask

  task automatic step(input bit rs, input bit we, input bit re,
                      input int wa, input int ra, input int d);
    @(negedge clock);
    #1;
    reset  = rs;
    wen    = we;
    ren    = re;
    w_addr = 4'(wa);
    r_addr = 4'(ra);
    data   = 15'(d);
    if (rs) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        chk("async_busy", k, 32'(out_b(k)), 32'd1);
        chk("async_qvalid", k, 32'(out_v(k)), 32'd0);
        chk("async_q", k, 32'(out_q(k)), 32'd0);
      end
    end
    for (int k = 0; k < 3; k++) model_edge(k, rs, we, re, wa, ra, d);
  endtask

  // Monitor: per-cycle status from the status queue, read data on q_valid.
  always @(negedge clock) begin
    stat_t       s;
    logic [14:0] exp_d;
    for (int k = 0; k < 3; k++) begin
      if (exp_st.size() > 0) begin
        s = exp_st.pop_front();
        chk("busy", k, 32'(out_b(k)), 32'(s.busy));
        chk("q_valid", k, 32'(out_v(k)), 32'(s.v));
        chk("addr_err", k, 32'(out_e(k)), 32'(s.e));
        chk("q_hold", k, 32'(out_q(k)), 32'(s.q));
      end
      if (out_v(k) === 1'b1) begin
        exp_d = 15'h7fff;
        case (k)
          0: if (rd_q0.size() > 0) exp_d = rd_q0.pop_front();
          1: if (rd_q1.size() > 0) exp_d = rd_q1.pop_front();
          default: if (rd_q2.size() > 0) exp_d = rd_q2.pop_front();
        endcase
        chk("read_data", k, 32'(out_q(k)), 32'(exp_d));
      end
    end
  end

  initial begin
    reset = 1'b1; wen = 1'b0; ren = 1'b0; data = '0; w_addr = '0; r_addr = '0;
    for (int k = 0; k < 3; k++) begin
      m_left[k] = dep(k);
      m_q[k] = 0;
    end

    repeat (3) step(1, 0, 0, 0, 0, 0);
    // Requests during init must be ignored.
    repeat (8) step(0, 1, 1, 0, 0, 'h7FFF);
    repeat (10) step(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 0, 1, 0, a, 0);

    step(0, 1, 0, 5, 0, 'h1234);
    step(0, 0, 1, 0, 5, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    step(0, 1, 1, 3, 3, 'h0ABC);
    step(0, 0, 1, 0, 3, 0);
    step(0, 0, 0, 0, 0, 0);

    step(0, 1, 1, 9, 12, 'h5555);
    step(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) step(0, 0, 1, 0, a, 0);
    step(0, 1, 1, 2, 15, 'h0111);
    step(0, 1, 1, 14, 2, 'h0222);

    for (int a = 0; a < 16; a++) step(0, 1, 0, a, 0, 'h7FFF);
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 1, 1, 'h7FFF);
    step(1, 0, 0, 0, 0, 0);
    repeat (18) step(0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 0, 1, 0, a, 0);

    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 32767)));
    end
    repeat (2) step(0, 0, 0, 0, 0, 0);

    @(negedge clock);
    #2;
    chk("status_drain", 0, 32'(exp_st.size()), 32'd0);
    chk("read_drain", 0, 32'(rd_q0.size()), 32'd0);
    chk("read_drain", 1, 32'(rd_q1.size()), 32'd0);
    chk("read_drain", 2, 32'(rd_q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
